// File: rtl/reg_pipe_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants and helpers for the 12x12 Booth multiplier
//               datapath pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Default datapath width of the multiplier operands
  localparam int DATA_W         = 12;

  // Deepest retiming pipeline supported between datapath sections
  localparam int MAX_PIPE_DEPTH = 16;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_pipe_n_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : One elastic pipeline stage: a valid bit plus a data register.
//               Data is only captured when a valid word arrives, so an
//               emptied stage keeps showing its last word.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage
  import mult_pkg::*;
#(
  parameter int NUMBER_OF_BITS = DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_flush,
  input  logic                      i_load,
  input  logic                      i_next_valid,
  input  logic [NUMBER_OF_BITS-1:0] i_data,
  output logic                      o_valid,
  output logic [NUMBER_OF_BITS-1:0] o_data
);

  logic                      r_valid;
  logic [NUMBER_OF_BITS-1:0] r_data;

  // Reset clears everything; flush clears only the valid bit; otherwise load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_next_valid;
      if (i_next_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/reg_pipe_n.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_n
// Description : DEPTH-stage elastic pipeline register with ready/valid
//               backpressure, bubble collapsing and synchronous flush.
//               Used to retime the Booth multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe_n
  import mult_pkg::*;
#(
  parameter  int NUMBER_OF_BITS = DATA_W,
  parameter  int DEPTH          = 2,
  localparam int OCC_BITS       = clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUMBER_OF_BITS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUMBER_OF_BITS-1:0] out_data,
  output logic [OCC_BITS-1:0]       occupancy
);

  logic [DEPTH-1:0]          w_valid;
  logic [NUMBER_OF_BITS-1:0] w_data [DEPTH];
  logic [DEPTH-1:0]          w_can_load;
  logic                      w_in_fire;
  logic [OCC_BITS-1:0]       w_occ;

  // Ready chain from the output side back: a stage can load when it is empty
  // or its own word moves on this cycle
  always_comb begin
    w_can_load            = '0;
    w_can_load[DEPTH-1]   = !w_valid[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_can_load[k] = !w_valid[k] || w_can_load[k + 1];
    end
  end

  assign in_ready  = w_can_load[0] && !flush && !reset;
  assign w_in_fire = in_valid && in_ready;

  // Stage 0 is fed from the input port, every later stage from its predecessor.
  // A stage that loads from an empty predecessor becomes a bubble, which is
  // how gaps close even while the output is stalled.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                      w_next_valid;
    logic [NUMBER_OF_BITS-1:0] w_din;

    if (k == 0) begin : g_head
      assign w_next_valid = w_in_fire;
      assign w_din        = in_data;
    end else begin : g_body
      assign w_next_valid = w_valid[k - 1];
      assign w_din        = w_data[k - 1];
    end

    pipe_stage #(
      .NUMBER_OF_BITS (NUMBER_OF_BITS)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .i_flush      (flush),
      .i_load       (w_can_load[k]),
      .i_next_valid (w_next_valid),
      .i_data       (w_din),
      .o_valid      (w_valid[k]),
      .o_data       (w_data[k])
    );
  end

  // Occupancy is a popcount of the registered valid bits only
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_BITS'(w_valid[k]);
    end
  end

  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];
  assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_pipe_n
// Description : Directed self-checking bench for reg_pipe_n at DEPTH=3 and
//               DEPTH=1. Both instances share the same stimulus; each phase
//               checks only the instance under test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_pipe_n;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [11:0] in_data;
  logic        out_ready;

  logic        in_ready3;
  logic        out_valid3;
  logic [11:0] out_data3;
  logic [1:0]  occ3;

  logic        in_ready1;
  logic        out_valid1;
  logic [11:0] out_data1;
  logic [0:0]  occ1;

  int n_checks;
  int n_pass;

  reg_pipe_n #(.NUMBER_OF_BITS(12), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out_data  (out_data3),
    .occupancy (occ3)
  );

  reg_pipe_n #(.NUMBER_OF_BITS(12), .DEPTH(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observation point between edges
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [11:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    drive(1'b1, 12'hFFF, 1'b1);

    // ---------------- 1. reset ----------------
    mid(); chk("rst_in_ready_c0", 32'(in_ready3), 32'd0);
    tick();
    mid();
    chk("rst_in_ready_c1", 32'(in_ready3), 32'd0);
    chk("rst_out_valid",   32'(out_valid3), 32'd0);
    chk("rst_out_data",    32'(out_data3), 32'h000);
    chk("rst_occ",         32'(occ3), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 12'h000, 1'b1);
    mid();
    chk("post_rst_in_ready", 32'(in_ready3), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid3), 32'd0);
    chk("post_rst_occ", 32'(occ3), 32'd0);
    tick();

    // ---------------- 2. streaming, DEPTH=3 ----------------
    for (int i = 0; i < 10; i++) begin
      drive(i < 5, 12'(i + 1), 1'b1);
      mid();
      if (i < 5) chk("strm3_in_ready", 32'(in_ready3), 32'd1);
      if (i >= 3 && i < 8) begin
        chk("strm3_out_valid", 32'(out_valid3), 32'd1);
        chk("strm3_out_data", 32'(out_data3), 32'(i - 2));
      end else begin
        chk("strm3_out_idle", 32'(out_valid3), 32'd0);
      end
      if (i >= 3 && i <= 5) chk("strm3_occ", 32'(occ3), 32'd3);
      tick();
    end

    // ---------------- 3. backpressure, DEPTH=3 ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'hA00 + 12'(i), 1'b0);
      mid();
      chk("bp3_accept", 32'(in_ready3), 32'd1);
      tick();
    end
    drive(1'b1, 12'hA03, 1'b0);
    mid();
    chk("bp3_full_in_ready", 32'(in_ready3), 32'd0);
    chk("bp3_full_occ", 32'(occ3), 32'd3);
    chk("bp3_full_data", 32'(out_data3), 32'hA00);
    tick();
    mid();
    chk("bp3_hold_data", 32'(out_data3), 32'hA00);
    chk("bp3_hold_valid", 32'(out_valid3), 32'd1);
    tick();
    drive(1'b1, 12'hA03, 1'b1);
    mid();
    chk("bp3_drain_fill_ready", 32'(in_ready3), 32'd1);
    chk("bp3_drain_fill_data", 32'(out_data3), 32'hA00);
    tick();
    drive(1'b0, 12'h000, 1'b0);
    mid();
    chk("bp3_after_occ", 32'(occ3), 32'd3);
    chk("bp3_after_data", 32'(out_data3), 32'hA01);
    chk("bp3_after_ready", 32'(in_ready3), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 12'h000, 1'b1);
      mid();
      if (i < 3) begin
        chk("bp3_drain_valid", 32'(out_valid3), 32'd1);
        chk("bp3_drain_data", 32'(out_data3), 32'hA01 + 32'(i));
      end else begin
        chk("bp3_drain_empty", 32'(out_valid3), 32'd0);
      end
      tick();
    end

    // ---------------- 4. bubble collapse, DEPTH=3 ----------------
    drive(1'b1, 12'h111, 1'b0); tick();
    drive(1'b0, 12'h000, 1'b0); tick();
    drive(1'b1, 12'h222, 1'b0); tick();
    drive(1'b0, 12'h000, 1'b0); tick();
    mid();
    chk("bub_occ", 32'(occ3), 32'd2);
    chk("bub_valid_map", 32'(u_dut3.w_valid), 32'b110);
    chk("bub_head", 32'(out_data3), 32'h111);
    tick();
    drive(1'b0, 12'h000, 1'b1);
    mid(); chk("bub_out0", 32'(out_data3), 32'h111); chk("bub_out0_v", 32'(out_valid3), 32'd1);
    tick();
    mid(); chk("bub_out1", 32'(out_data3), 32'h222); chk("bub_out1_v", 32'(out_valid3), 32'd1);
    tick();
    mid(); chk("bub_empty", 32'(out_valid3), 32'd0);
    tick();

    // ---------------- 5. flush, DEPTH=3 ----------------
    drive(1'b1, 12'h301, 1'b0); tick();
    drive(1'b1, 12'h302, 1'b0); tick();
    drive(1'b1, 12'h5A5, 1'b0);
    flush = 1'b1;
    mid();
    chk("fl_pre_occ", 32'(occ3), 32'd2);
    chk("fl_in_ready", 32'(in_ready3), 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 12'h000, 1'b1);
    mid();
    chk("fl_occ", 32'(occ3), 32'd0);
    chk("fl_out_valid", 32'(out_valid3), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("fl_no_emerge", 32'(out_valid3), 32'd0);
      tick();
    end

    // ---------------- 6. reset mid-stream with flush ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'hB01 + 12'(i), 1'b0);
      tick();
    end
    drive(1'b1, 12'hB04, 1'b1);
    reset = 1'b1;
    flush = 1'b1;
    mid();
    chk("rmid_pre_occ", 32'(occ3), 32'd3);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 12'h000, 1'b1);
    mid();
    chk("rmid_out_valid", 32'(out_valid3), 32'd0);
    chk("rmid_out_data", 32'(out_data3), 32'h000);
    chk("rmid_occ", 32'(occ3), 32'd0);
    chk("rmid_in_ready", 32'(in_ready3), 32'd1);
    chk("rmid_d1_out_data", 32'(out_data1), 32'h000);
    tick();

    // ---------------- DEPTH=1 streaming ----------------
    for (int i = 0; i < 7; i++) begin
      drive(i < 5, 12'h100 + 12'(i), 1'b1);
      mid();
      if (i < 5) chk("strm1_in_ready", 32'(in_ready1), 32'd1);
      if (i >= 1 && i <= 5) begin
        chk("strm1_out_valid", 32'(out_valid1), 32'd1);
        chk("strm1_out_data", 32'(out_data1), 32'h100 + 32'(i - 1));
      end else begin
        chk("strm1_out_idle", 32'(out_valid1), 32'd0);
      end
      if (i >= 1 && i <= 4) chk("strm1_occ", 32'(occ1), 32'd1);
      tick();
    end

    // ---------------- DEPTH=1 backpressure ----------------
    drive(1'b1, 12'hC00, 1'b0);
    mid(); chk("bp1_accept", 32'(in_ready1), 32'd1);
    tick();
    drive(1'b1, 12'hC01, 1'b0);
    mid();
    chk("bp1_stall_ready", 32'(in_ready1), 32'd0);
    chk("bp1_stall_occ", 32'(occ1), 32'd1);
    chk("bp1_stall_data", 32'(out_data1), 32'hC00);
    tick();
    drive(1'b1, 12'hC01, 1'b1);
    mid();
    chk("bp1_swap_ready", 32'(in_ready1), 32'd1);
    chk("bp1_swap_data", 32'(out_data1), 32'hC00);
    tick();
    drive(1'b0, 12'h000, 1'b0);
    mid();
    chk("bp1_next_data", 32'(out_data1), 32'hC01);
    chk("bp1_next_valid", 32'(out_valid1), 32'd1);
    chk("bp1_next_ready", 32'(in_ready1), 32'd0);
    tick();
    drive(1'b0, 12'h000, 1'b1);
    tick();
    mid();
    chk("bp1_empty", 32'(out_valid1), 32'd0);
    chk("bp1_empty_occ", 32'(occ1), 32'd0);
    chk("bp1_retained_data", 32'(out_data1), 32'hC01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
